// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//
// Two-port round-robin arbiter in front of a single-ported SRAM controller.
// Port 0 is the data-memory stage and port 1 is a secondary master, such as
// instruction fetch or a debug loader. When a port wins arbitration, its
// operation is latched into op registers. Those registers drive the controller
// until it signals mem_ready. The completion and the read data are returned
// only to the owning port, and the other port is stalled meanwhile.
//
// Ports
//   clk, rst                 system clock, asynchronous active-high reset
//   reqN_r_en, reqN_w_en     level read/write request (both set = write)
//   reqN_addr, reqN_wdata    request address / write data
//   reqN_rdata               read data (mem_rdata pass-through)
//   reqN_ready               completion strobe; 1 whenever port N is idle
//   mem_r_en, mem_w_en       registered controller enables
//   mem_addr, mem_wdata      registered controller address / write data
//   mem_rdata, mem_ready     controller read data / completion
//   busy                     1 while a transaction is owned
// -----------------------------------------------------------------------------
module sram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0_r_en,
  input  logic              req0_w_en,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_ready,

  input  logic              req1_r_en,
  input  logic              req1_w_en,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_ready,

  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,

  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              last_grant, last_grant_nxt;
  logic              mem_r_en_nxt, mem_w_en_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt;

  logic req0_active, req1_active;
  logic grant0, grant1;

  assign req0_active = req0_r_en | req0_w_en;
  assign req1_active = req1_r_en | req1_w_en;

  // Round-robin choice in IDLE. On a tie, the port not served last wins.
  // last_grant resets to 1, so port 0 wins the first tie.
  assign grant0 = req0_active && (!req1_active || last_grant);
  assign grant1 = req1_active && !grant0;

  // NOTE: every variable gets a default before the case statement. A path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    mem_r_en_nxt   = mem_r_en;
    mem_w_en_nxt   = mem_w_en;
    mem_addr_nxt   = mem_addr;
    mem_wdata_nxt  = mem_wdata;

    unique case (state)
      IDLE: begin
        if (grant0) begin
          state_nxt     = GRANT0;
          mem_w_en_nxt  = req0_w_en;
          mem_r_en_nxt  = ~req0_w_en;
          mem_addr_nxt  = req0_addr;
          mem_wdata_nxt = req0_wdata;
        end else if (grant1) begin
          state_nxt     = GRANT1;
          mem_w_en_nxt  = req1_w_en;
          mem_r_en_nxt  = ~req1_w_en;
          mem_addr_nxt  = req1_addr;
          mem_wdata_nxt = req1_wdata;
        end
      end
      GRANT0, GRANT1: begin
        // The enable is held until the controller finishes, even if the
        // requester has withdrawn, so the controller's cycle count always
        // runs to completion.
        if (mem_ready) begin
          state_nxt      = IDLE;
          last_grant_nxt = (state == GRANT1);
          mem_r_en_nxt   = 1'b0;
          mem_w_en_nxt   = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments. All registers then
  // update together at the edge, whatever order the statements are in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      mem_r_en   <= 1'b0;
      mem_w_en   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      mem_r_en   <= mem_r_en_nxt;
      mem_w_en   <= mem_w_en_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
    end
  end

  assign busy = (state != IDLE);

  // A port that is not requesting sees ready=1. An active port sees ready=1
  // only on its own completion cycle. The completion of a withdrawn request
  // therefore never reaches that port.
  assign req0_ready = !req0_active || (state == GRANT0 && mem_ready);
  assign req1_ready = !req1_active || (state == GRANT1 && mem_ready);

  assign req0_rdata = mem_rdata;
  assign req1_rdata = mem_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
//
// Self-checking bench for sram_arbiter. A behavioural SRAM controller raises
// mem_ready on the 7th consecutive enabled cycle. Each expected completion
// (port, cycle, read data) is queued when stimulus is driven. It is popped and
// compared when a port observes ready while requesting. Inputs are driven 1 time
// unit after posedge, and outputs are sampled on negedge.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_r_en, req0_w_en, req1_r_en, req1_w_en;
  logic [ADDR_W-1:0] req0_addr, req1_addr;
  logic [DATA_W-1:0] req0_wdata, req1_wdata, req0_rdata, req1_rdata;
  logic              req0_ready, req1_ready;
  logic              mem_r_en, mem_w_en, mem_ready, busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_r_en  (req0_r_en),
    .req0_w_en  (req0_w_en),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_rdata (req0_rdata),
    .req0_ready (req0_ready),
    .req1_r_en  (req1_r_en),
    .req1_w_en  (req1_w_en),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_rdata (req1_rdata),
    .req1_ready (req1_ready),
    .mem_r_en   (mem_r_en),
    .mem_w_en   (mem_w_en),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- SRAM controller model ----------------
  logic [31:0] sram [0:1023];
  logic [2:0]  cnt;

  function automatic logic [31:0] init_word(input logic [9:0] idx);
    if (idx == 10'd256)      return 32'hDEADBEEF;   // 0x400
    else if (idx == 10'd258) return 32'hCAFEF00D;   // 0x408
    else                     return 32'hA5C30000 | 32'(idx);
  endfunction

  assign mem_ready = (mem_r_en | mem_w_en) && (cnt == 3'd6);
  assign mem_rdata = mem_r_en ? sram[mem_addr[11:2]] : '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 3'd0;
      for (int i = 0; i < 1024; i++) sram[i] <= init_word(i[9:0]);
    end else begin
      if (mem_r_en | mem_w_en) cnt <= mem_ready ? 3'd0 : cnt + 3'd1;
      else                     cnt <= 3'd0;
      if (mem_w_en && mem_ready) sram[mem_addr[11:2]] <= mem_wdata;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int          port;
    bit          is_read;
    logic [31:0] rdata;
    int          cycle;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Waits for the sample point and retires any completion seen this cycle.
  task automatic sample();
    exp_t e;
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      logic        act, rdy;
      logic [31:0] rd;
      act = (p == 0) ? (req0_r_en | req0_w_en) : (req1_r_en | req1_w_en);
      rdy = (p == 0) ? req0_ready : req1_ready;
      rd  = (p == 0) ? req0_rdata : req1_rdata;
      if (act && rdy) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: port %0d completed in cycle %0d, none expected", p, cyc);
        end else begin
          e = sb_q.pop_front();
          if (e.port != p || e.cycle != cyc || (e.is_read && rd !== e.rdata)) begin
            errors++;
            $display("FAIL sb_completion: got port %0d cycle %0d rdata %h, expected port %0d cycle %0d rdata %h",
                     p, cyc, rd, e.port, e.cycle, e.rdata);
          end
        end
      end
    end
  endtask

  task automatic idle_inputs();
    req0_r_en = 0; req0_w_en = 0; req0_addr = '0; req0_wdata = '0;
    req1_r_en = 0; req1_w_en = 0; req1_addr = '0; req1_wdata = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({mem_r_en, mem_w_en, busy, req0_ready, req1_ready} !== 5'b00011) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00011", {mem_r_en, mem_w_en, busy, req0_ready, req1_ready});
    end
    checks++;
    if ({mem_addr, mem_wdata} !== 64'd0) begin
      errors++;
      $display("FAIL reset_bus: got addr %h wdata %h expected 0", mem_addr, mem_wdata);
    end
    req0_r_en = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_active_stall: got req0_ready %b expected 0", req0_ready);
    end
    req0_r_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Both ports active in the same cycle right after reset.
  task automatic run_tie(input string name);
    int base;
    logic [3:0] expv;
    next_cycle();
    base = cyc;
    req0_r_en = 1; req0_addr = 32'h400;
    req1_r_en = 1; req1_addr = 32'h408;
    sb_q.push_back('{0, 1'b1, 32'hDEADBEEF, base + 7});
    sb_q.push_back('{1, 1'b1, 32'hCAFEF00D, base + 15});
    for (int c = 0; c <= 16; c++) begin
      logic en;
      sample();
      en   = (c >= 1 && c <= 7) || (c >= 9 && c <= 15);
      expv = {en, en, c >= 7, c >= 15};
      checks++;
      if ({mem_r_en, busy, req0_ready, req1_ready} !== expv) begin
        errors++;
        $display("FAIL %s c%0d: got {r_en,busy,rdy0,rdy1}=%b expected %b", name, c,
                 {mem_r_en, busy, req0_ready, req1_ready}, expv);
      end
      if (en) begin
        checks++;
        if (mem_addr !== ((c <= 7) ? 32'h400 : 32'h408)) begin
          errors++;
          $display("FAIL %s_addr c%0d: got %h expected %h", name, c, mem_addr, (c <= 7) ? 32'h400 : 32'h408);
        end
      end
      next_cycle();
      if (c == 7)  req0_r_en = 0;
      if (c == 15) req1_r_en = 0;
    end
  endtask

  task automatic test_tie();
    run_tie("tie");
  endtask

  task automatic test_back_to_back();
    int base;
    next_cycle();
    base = cyc;
    req0_r_en = 1; req0_addr = 32'h410;
    req1_r_en = 1; req1_addr = 32'h414;
    for (int k = 0; k < 4; k++)
      sb_q.push_back('{k % 2, 1'b1, init_word((k % 2 == 0) ? 10'd260 : 10'd261), base + 8 * k + 7});
    for (int c = 0; c <= 32; c++) begin
      logic        en;
      logic [31:0] ea;
      sample();
      en = (c % 8 != 0) && (c < 32);
      ea = ((c / 8) % 2 == 0) ? 32'h410 : 32'h414;
      checks++;
      if (mem_r_en !== en || (en && mem_addr !== ea)) begin
        errors++;
        $display("FAIL b2b c%0d: got r_en %b addr %h expected r_en %b addr %h", c, mem_r_en, mem_addr, en, ea);
      end
      next_cycle();
      if (c == 31) begin req0_r_en = 0; req1_r_en = 0; end
    end
  endtask

  task automatic test_write_both_en();
    int base;
    next_cycle();
    base = cyc;
    req1_r_en = 1; req1_w_en = 1; req1_addr = 32'h404; req1_wdata = 32'h12345678;
    sb_q.push_back('{1, 1'b0, 32'h0, base + 7});
    for (int c = 0; c <= 8; c++) begin
      logic en;
      sample();
      en = (c >= 1 && c <= 7);
      checks++;
      if ({mem_r_en, mem_w_en, busy, req1_ready} !== {1'b0, en, en, c >= 7}) begin
        errors++;
        $display("FAIL wr_ctrl c%0d: got {r_en,w_en,busy,rdy1}=%b expected %b", c,
                 {mem_r_en, mem_w_en, busy, req1_ready}, {1'b0, en, en, c >= 7});
      end
      if (en) begin
        checks++;
        if (mem_addr !== 32'h404 || mem_wdata !== 32'h12345678) begin
          errors++;
          $display("FAIL wr_bus c%0d: got addr %h wdata %h expected 00000404 12345678", c, mem_addr, mem_wdata);
        end
      end
      next_cycle();
      // Requester bus changes during the grant must not reach the controller.
      if (c == 2) begin req1_addr = 32'h7FC; req1_wdata = 32'hFFFFFFFF; end
      if (c == 7) begin req1_r_en = 0; req1_w_en = 0; end
    end
    checks++;
    if (sram[257] !== 32'h12345678) begin
      errors++;
      $display("FAIL wr_stored: got %h expected 12345678", sram[257]);
    end
  endtask

  task automatic test_withdraw();
    int base;
    next_cycle();
    base = cyc;
    req0_r_en = 1; req0_addr = 32'h408;
    for (int c = 0; c <= 16; c++) begin
      logic       en;
      logic [3:0] expv;
      sample();
      en   = (c >= 1 && c <= 7) || (c >= 9 && c <= 15);
      expv = {en, en, c >= 3, !(c >= 8 && c <= 14)};
      checks++;
      if ({mem_r_en, busy, req0_ready, req1_ready} !== expv) begin
        errors++;
        $display("FAIL withdraw c%0d: got {r_en,busy,rdy0,rdy1}=%b expected %b", c,
                 {mem_r_en, busy, req0_ready, req1_ready}, expv);
      end
      next_cycle();
      if (c == 2) req0_r_en = 0;
      if (c == 7) begin
        req1_r_en = 1; req1_addr = 32'h400;
        sb_q.push_back('{1, 1'b1, 32'hDEADBEEF, base + 15});
      end
      if (c == 15) req1_r_en = 0;
    end
  endtask

  task automatic test_read_alone();
    int base;
    next_cycle();
    base = cyc;
    req0_r_en = 1; req0_addr = 32'h400;
    sb_q.push_back('{0, 1'b1, 32'hDEADBEEF, base + 7});
    for (int c = 0; c <= 8; c++) begin
      logic       en;
      logic [4:0] expv;
      sample();
      en   = (c >= 1 && c <= 7);
      expv = {en, 1'b0, en, c >= 7, 1'b1};
      checks++;
      if ({mem_r_en, mem_w_en, busy, req0_ready, req1_ready} !== expv) begin
        errors++;
        $display("FAIL rd_alone c%0d: got {r_en,w_en,busy,rdy0,rdy1}=%b expected %b", c,
                 {mem_r_en, mem_w_en, busy, req0_ready, req1_ready}, expv);
      end
      next_cycle();
      if (c == 7) req0_r_en = 0;
    end
  endtask

  // Port 0 was served last before this test. Only the reset value of
  // last_grant can make port 0 win the tie that follows.
  task automatic test_reset_mid();
    next_cycle();
    req1_w_en = 1; req1_addr = 32'h40C; req1_wdata = 32'hA5A5A5A5;
    for (int c = 0; c <= 3; c++) begin
      sample();
      checks++;
      if (mem_w_en !== (c >= 1)) begin
        errors++;
        $display("FAIL rstmid_pre c%0d: got w_en %b expected %b", c, mem_w_en, c >= 1);
      end
      next_cycle();
    end
    req1_w_en = 0;
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_r_en, mem_w_en, busy} !== 3'b000) begin
      errors++;
      $display("FAIL rstmid_async: got {r_en,w_en,busy}=%b expected 000", {mem_r_en, mem_w_en, busy});
    end
    #2;
    rst = 1'b0;
    sample();
    checks++;
    if ({mem_w_en, busy} !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_idle: got {w_en,busy}=%b expected 00", {mem_w_en, busy});
    end
    run_tie("rstmid_tie");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_tie();
    test_back_to_back();
    test_write_both_en();
    test_withdraw();
    test_read_alone();
    test_reset_mid();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending completions expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
